mc_ctrl_fsm: RTL and testbench

//  Control unit for the multi-cycle MIPS core: a Moore FSM that sequences each instruction through fetch/decode/execute/mem/writeback.

---
 rtl/mc_pkg.sv | 81 ++++++++
 rtl/mc_ctrl_decode.sv | 111 +++++++++++
 rtl/mc_ctrl_fsm.sv | 103 ++++++++++
 tb/tb_mc_ctrl_fsm.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes, opcodes,
// control-word layout and datapath mux encodings.
package mc_pkg;

   localparam int unsigned CTRL_W = 20;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [4:0] {
      S_IF     = 5'd0,  S_ID     = 5'd1,  S_EX_R  = 5'd2,  S_EX_I = 5'd3,
      S_MA     = 5'd4,  S_MEM_RD = 5'd5,  S_MEM_WR = 5'd6, S_WB_R = 5'd7,
      S_WB_I   = 5'd8,  S_WB_LW  = 5'd9,  S_BR    = 5'd10, S_J    = 5'd11,
      S_JAL    = 5'd12, S_JR     = 5'd13, S_INT   = 5'd14, S_ERET = 5'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_COP0  = 6'b010000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ERET  = 6'b011000;

   // Bit positions of the fields inside the 20-bit control word
   localparam int unsigned CTRL_PC_WRITE      = 19;
   localparam int unsigned CTRL_PC_WRITE_COND = 18;
   localparam int unsigned CTRL_I_OR_D        = 17;
   localparam int unsigned CTRL_MEM_READ      = 16;
   localparam int unsigned CTRL_MEM_WRITE     = 15;
   localparam int unsigned CTRL_IR_WRITE      = 14;
   localparam int unsigned CTRL_REG_WRITE     = 13;
   localparam int unsigned CTRL_ALU_SRC_A     = 12;
   localparam int unsigned CTRL_EPC_WRITE     = 11;
   localparam int unsigned CTRL_BR_NE         = 10;
   localparam int unsigned CTRL_MEM_TO_REG    = 8;
   localparam int unsigned CTRL_PC_SOURCE     = 6;
   localparam int unsigned CTRL_ALU_SRC_B     = 4;
   localparam int unsigned CTRL_REG_DST       = 2;
   localparam int unsigned CTRL_ALU_OP        = 0;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_IMM   = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_VEC    = 2'b11;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       alu_src_a;
      logic       epc_write;
      logic       br_ne;
      logic [1:0] mem_to_reg;
      logic [1:0] pc_source;
      logic [1:0] alu_src_b;
      logic [1:0] reg_dst;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore decode of the control state into the datapath control word and bus request;
// write strobes are forced low while reset is held.
module mc_ctrl_decode
   import mc_pkg::*;
(
   input  state_t     state,
   input  logic       mio_ready,
   input  logic       reset,
   input  logic [5:0] opcode,
   output ctrl_t      ctrl_c,
   output logic       cpu_mio_c
);

   always_comb begin
      ctrl_c    = '0;
      cpu_mio_c = 1'b0;
      case (state)
         S_IF: begin
            cpu_mio_c          = 1'b1;
            ctrl_c.mem_read    = 1'b1;
            ctrl_c.alu_src_b   = SRCB_FOUR;
            ctrl_c.alu_op      = ALUOP_ADD;
            ctrl_c.ir_write    = mio_ready;
            ctrl_c.pc_write    = mio_ready;
         end
         S_ID:   ctrl_c.alu_src_b = SRCB_BRANCH;
         S_EX_R: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRCB_REG;
            ctrl_c.alu_op    = ALUOP_FUNCT;
         end
         S_EX_I: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRCB_IMM;
            ctrl_c.alu_op    = ALUOP_IMM;
         end
         S_MA: begin
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRCB_IMM;
            ctrl_c.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            cpu_mio_c       = 1'b1;
            ctrl_c.i_or_d   = 1'b1;
            ctrl_c.mem_read = 1'b1;
         end
         S_MEM_WR: begin
            cpu_mio_c        = 1'b1;
            ctrl_c.i_or_d    = 1'b1;
            ctrl_c.mem_write = 1'b1;
         end
         S_WB_R: begin
            ctrl_c.reg_dst   = 2'b01;
            ctrl_c.reg_write = 1'b1;
         end
         S_WB_I:  ctrl_c.reg_write = 1'b1;
         S_WB_LW: begin
            ctrl_c.mem_to_reg = 2'b01;
            ctrl_c.reg_write  = 1'b1;
         end
         S_BR: begin
            ctrl_c.alu_src_a     = 1'b1;
            ctrl_c.alu_src_b     = SRCB_REG;
            ctrl_c.alu_op        = ALUOP_SUB;
            ctrl_c.pc_write_cond = 1'b1;
            ctrl_c.br_ne         = (opcode == OP_BNE);
            ctrl_c.pc_source     = PCSRC_ALUOUT;
         end
         S_J: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PCSRC_JUMP;
         end
         S_JAL: begin
            ctrl_c.pc_write   = 1'b1;
            ctrl_c.pc_source  = PCSRC_JUMP;
            ctrl_c.reg_dst    = 2'b10;
            ctrl_c.mem_to_reg = 2'b10;
            ctrl_c.reg_write  = 1'b1;
         end
         // rs + 0 through the ALU, taken straight onto PC
         S_JR: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PCSRC_ALU;
            ctrl_c.alu_src_a = 1'b1;
            ctrl_c.alu_src_b = SRCB_REG;
            ctrl_c.alu_op    = ALUOP_ADD;
         end
         S_INT: begin
            ctrl_c.epc_write = 1'b1;
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PCSRC_VEC;
         end
         // ALUOp=11 tells the datapath to route EPC onto the vector input
         S_ERET: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_source = PCSRC_VEC;
            ctrl_c.alu_op    = ALUOP_IMM;
         end
         default: ctrl_c = '0;
      endcase
      if (reset) begin
         ctrl_c.pc_write      = 1'b0;
         ctrl_c.pc_write_cond = 1'b0;
         ctrl_c.ir_write      = 1'b0;
         ctrl_c.reg_write     = 1'b0;
         ctrl_c.mem_write     = 1'b0;
         ctrl_c.epc_write     = 1'b0;
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: instruction sequencing, memory wait states with optional
// timeout, and interrupt entry at instruction boundaries.
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter logic        INT_EN_RESET = 1'b0,
   parameter int unsigned WAIT_MAX     = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MIO_ready,
   input  logic              INT,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic              zero,
   output logic [CTRL_W-1:0] ctrl,
   output logic              CPU_MIO,
   output logic              mem_err,
   output logic [4:0]        state
);

   state_t           st;
   state_t           end_st;
   logic             int_en;
   logic [CNT_W-1:0] wait_cnt;
   logic             in_wait;
   logic             timeout;
   ctrl_t            ctrl_w;
   logic             unused_zero;

   // Branch resolution (zero ^ BrNe) happens in the datapath
   assign unused_zero = zero;

   assign in_wait = (st == S_IF) || (st == S_MEM_RD) || (st == S_MEM_WR);
   assign timeout = (WAIT_MAX != 0) && in_wait && !MIO_ready &&
                    (wait_cnt == CNT_W'(WAIT_MAX - 1));
   assign end_st  = (INT && int_en) ? S_INT : S_IF;
   assign mem_err = timeout && !reset;
   assign state   = st;
   assign ctrl    = ctrl_w;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st       <= S_IF;
         int_en   <= INT_EN_RESET;
         wait_cnt <= '0;
      end else begin
         // Consecutive-stall counter, saturating; cleared on progress or timeout
         if (in_wait && !MIO_ready && !timeout) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end

         case (st)
            S_IF:     if (MIO_ready) st <= S_ID;
            S_ID: begin
               case (opcode)
                  OP_RTYPE:                             st <= (funct == FN_JR) ? S_JR : S_EX_R;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: st <= S_EX_I;
                  OP_LW, OP_SW:                         st <= S_MA;
                  OP_BEQ, OP_BNE:                       st <= S_BR;
                  OP_J:                                 st <= S_J;
                  OP_JAL:                               st <= S_JAL;
                  OP_COP0:                              st <= (funct == FN_ERET) ? S_ERET : S_IF;
                  default:                              st <= S_IF;
               endcase
            end
            S_EX_R:   st <= S_WB_R;
            S_EX_I:   st <= S_WB_I;
            S_MA:     st <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
               if (timeout)        st <= S_IF;
               else if (MIO_ready) st <= S_WB_LW;
            end
            S_MEM_WR: begin
               if (timeout)        st <= S_IF;
               else if (MIO_ready) st <= end_st;
            end
            S_WB_R, S_WB_I, S_WB_LW, S_BR, S_J, S_JAL, S_JR: st <= end_st;
            S_INT: begin
               st     <= S_IF;
               int_en <= 1'b0;
            end
            S_ERET: begin
               st     <= S_IF;
               int_en <= 1'b1;
            end
            default:  st <= S_IF;
         endcase
      end
   end

   mc_ctrl_decode u_decode (
      .state     (st),
      .mio_ready (MIO_ready),
      .reset     (reset),
      .opcode    (opcode),
      .ctrl_c    (ctrl_w),
      .cpu_mio_c (CPU_MIO)
   );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed table-driven bench for mc_ctrl_fsm with WAIT_MAX=4 and int_en cleared at reset.
module tb_mc_ctrl_fsm;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        irq;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic [4:0]  st;
      logic [19:0] cw;
      logic        mio;
      logic        err;
   } vec_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_JR    = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_COP0 = 6'b010000;
   localparam logic [5:0] F_ERET  = 6'b011000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic        clk = 1'b0;
   logic        reset, MIO_ready, INT, zero;
   logic [5:0]  opcode, funct;
   logic [19:0] ctrl;
   logic        CPU_MIO, mem_err;
   logic [4:0]  state;

   int n_vec = 0;
   int n_bad = 0;
   vec_t tab[$];

   logic [19:0] c_ifw, c_ifg, c_id, c_exr, c_exi, c_ma, c_mrd, c_mwr, c_wbr, c_wbi,
                c_wblw, c_beq, c_bne, c_j, c_jal, c_jr, c_int, c_eret;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.INT_EN_RESET(1'b0), .WAIT_MAX(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .MIO_ready (MIO_ready),
      .INT       (INT),
      .opcode    (opcode),
      .funct     (funct),
      .zero      (zero),
      .ctrl      (ctrl),
      .CPU_MIO   (CPU_MIO),
      .mem_err   (mem_err),
      .state     (state)
   );

   // Control word, fields listed MSB first
   function automatic logic [19:0] cw(input logic pcw, pcwc, iord, mrd, mwr, irw, rw, srca,
                                      epc, brne, input logic [1:0] m2r, pcs, srcb, rdst, aop);
      return {pcw, pcwc, iord, mrd, mwr, irw, rw, srca, epc, brne, m2r, pcs, srcb, rdst, aop};
   endfunction

   task automatic add(input logic rst, rdy, irq, input logic [5:0] op, fn, input logic z,
                      input logic [4:0] st, input logic [19:0] w, input logic mio, err);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.irq = irq; v.op = op; v.fn = fn; v.z = z;
      v.st = st; v.cw = w; v.mio = mio; v.err = err;
      tab.push_back(v);
   endtask

   // Fetch (MIO_ready=1) and decode cycles of one instruction
   task automatic add_fd(input logic irq, input logic [5:0] op, fn, input logic z);
      add(0, 1, irq, op, fn, z, 5'd0, c_ifg, 1, 0);
      add(0, 1, irq, op, fn, z, 5'd1, c_id, 0, 0);
   endtask

   task automatic apply(input vec_t v, input int idx);
      reset = v.rst; MIO_ready = v.rdy; INT = v.irq; opcode = v.op; funct = v.fn; zero = v.z;
      @(negedge clk);
      n_vec++;
      if ({state, ctrl, CPU_MIO, mem_err} !== {v.st, v.cw, v.mio, v.err}) begin
         n_bad++;
         $display("FAIL vec%0d: got state=%0d ctrl=%05h mio=%0b err=%0b, want state=%0d ctrl=%05h mio=%0b err=%0b",
                  idx, state, ctrl, CPU_MIO, mem_err, v.st, v.cw, v.mio, v.err);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   initial begin
      int split;
      c_ifw  = cw(0,0,0,1,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00);
      c_ifg  = cw(1,0,0,1,0,1,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00);
      c_id   = cw(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b11,2'b00,2'b00);
      c_exr  = cw(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b10);
      c_exi  = cw(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b10,2'b00,2'b11);
      c_ma   = cw(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b10,2'b00,2'b00);
      c_mrd  = cw(0,0,1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00);
      c_mwr  = cw(0,0,1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00);
      c_wbr  = cw(0,0,0,0,0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b01,2'b00);
      c_wbi  = cw(0,0,0,0,0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00);
      c_wblw = cw(0,0,0,0,0,0,1,0,0,0, 2'b01,2'b00,2'b00,2'b00,2'b00);
      c_beq  = cw(0,1,0,0,0,0,0,1,0,0, 2'b00,2'b01,2'b00,2'b00,2'b01);
      c_bne  = cw(0,1,0,0,0,0,0,1,0,1, 2'b00,2'b01,2'b00,2'b00,2'b01);
      c_j    = cw(1,0,0,0,0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00,2'b00);
      c_jal  = cw(1,0,0,0,0,0,1,0,0,0, 2'b10,2'b10,2'b00,2'b10,2'b00);
      c_jr   = cw(1,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00);
      c_int  = cw(1,0,0,0,0,0,0,0,1,0, 2'b00,2'b11,2'b00,2'b00,2'b00);
      c_eret = cw(1,0,0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b00,2'b00,2'b11);

      // Reset gates fetch strobes; add; lw with 3 stall cycles; beq/bne
      add(1, 1, 0, OP_R, F_ADD, 0, 5'd0, c_ifw, 1, 0);
      add_fd(0, OP_R, F_ADD, 0);
      add(0, 1, 0, OP_R, F_ADD, 0, 5'd2, c_exr, 0, 0);
      add(0, 1, 0, OP_R, F_ADD, 0, 5'd7, c_wbr, 0, 0);
      add_fd(0, OP_LW, 6'd0, 0);
      add(0, 1, 0, OP_LW, 6'd0, 0, 5'd4, c_ma, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, OP_LW, 6'd0, 0, 5'd5, c_mrd, 1, 0);
      add(0, 1, 0, OP_LW, 6'd0, 0, 5'd5, c_mrd, 1, 0);
      add(0, 1, 0, OP_LW, 6'd0, 0, 5'd9, c_wblw, 0, 0);
      add_fd(0, OP_BEQ, 6'd0, 1);
      add(0, 1, 0, OP_BEQ, 6'd0, 1, 5'd10, c_beq, 0, 0);
      add_fd(0, OP_BNE, 6'd0, 1);
      add(0, 1, 0, OP_BNE, 6'd0, 1, 5'd10, c_bne, 0, 0);
      // Undefined opcode, then fetch timeout on the 4th stalled cycle
      add_fd(0, OP_BAD, 6'd0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, OP_BAD, 6'd0, 0, 5'd0, c_ifw, 1, 0);
      add(0, 0, 0, OP_BAD, 6'd0, 0, 5'd0, c_ifw, 1, 1);
      add(0, 0, 0, OP_BAD, 6'd0, 0, 5'd0, c_ifw, 1, 0);
      // sw stalled in MEM_WR
      add_fd(0, OP_SW, 6'd0, 0);
      add(0, 1, 0, OP_SW, 6'd0, 0, 5'd4, c_ma, 0, 0);
      for (int i = 0; i < 2; i++) add(0, 0, 0, OP_SW, 6'd0, 0, 5'd6, c_mwr, 1, 0);
      split = tab.size();
      // Jumps, immediate op with INT while disabled, ERET, then INT taken once
      add_fd(0, OP_J, 6'd0, 0);
      add(0, 1, 0, OP_J, 6'd0, 0, 5'd11, c_j, 0, 0);
      add_fd(0, OP_JAL, 6'd0, 0);
      add(0, 1, 0, OP_JAL, 6'd0, 0, 5'd12, c_jal, 0, 0);
      add_fd(0, OP_R, F_JR, 0);
      add(0, 1, 0, OP_R, F_JR, 0, 5'd13, c_jr, 0, 0);
      add_fd(0, OP_ADDI, 6'd0, 0);
      add(0, 1, 0, OP_ADDI, 6'd0, 0, 5'd3, c_exi, 0, 0);
      add(0, 1, 1, OP_ADDI, 6'd0, 0, 5'd8, c_wbi, 0, 0);
      add(0, 0, 1, OP_ADDI, 6'd0, 0, 5'd0, c_ifw, 1, 0);
      add_fd(0, OP_COP0, F_ERET, 0);
      add(0, 1, 0, OP_COP0, F_ERET, 0, 5'd15, c_eret, 0, 0);
      add_fd(0, OP_R, F_ADD, 0);
      add(0, 1, 1, OP_R, F_ADD, 0, 5'd2, c_exr, 0, 0);
      add(0, 1, 1, OP_R, F_ADD, 0, 5'd7, c_wbr, 0, 0);
      add(0, 1, 1, OP_R, F_ADD, 0, 5'd14, c_int, 0, 0);
      add_fd(1, OP_R, F_ADD, 0);
      add(0, 1, 1, OP_R, F_ADD, 0, 5'd2, c_exr, 0, 0);
      add(0, 1, 1, OP_R, F_ADD, 0, 5'd7, c_wbr, 0, 0);
      add(0, 0, 1, OP_R, F_ADD, 0, 5'd0, c_ifw, 1, 0);

      reset = 1'b0; MIO_ready = 1'b0; INT = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
      #1;
      for (int i = 0; i < split; i++) apply(tab[i], i);

      // Asynchronous reset in the middle of a MEM_WR stall
      MIO_ready = 1'b0;
      #1;
      chk("mwr_hold", {27'd0, state, ctrl[15], CPU_MIO}, {27'd0, 5'd6, 1'b1, 1'b1});
      reset = 1'b1;
      #1;
      chk("rst_state", {27'd0, state}, 32'd0);
      chk("rst_memwrite", {31'd0, ctrl[15]}, 32'd0);
      chk("rst_ctrl", {12'd0, ctrl}, {12'd0, c_ifw});
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = split; i < tab.size(); i++) apply(tab[i], i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
